// File: rtl/conv_window_buffer_pkg.sv
// Shared defaults and window indexing for the convolution datapath
// (window buffer, multiplier, adder tree).
package conv_window_buffer_pkg;

    localparam int DEF_KERNEL_SIZE  = 5;
    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_IMAGE_WIDTH  = 28;
    localparam int DEF_IMAGE_HEIGHT = 28;

    // Flat element index of window position (r, c); r=0 is the oldest row.
    function automatic int win_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/conv_window_buffer_line_buffer.sv
// One image row of delay: dout is the pixel written DEPTH accepted pixels ago.
module conv_window_buffer_line_buffer #(
    parameter int DEPTH      = 28,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         ptr;

    // Read-before-write at the same slot turns a circular RAM into a fixed delay.
    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (shift_en) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        end
    end

    // NOTE: the RAM has no reset; stale rows are gated out by the window-valid
    // row check, so resetting it would only cost a clear sequence.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/conv_window_buffer.sv
// Raster-order pixel stream to KxK sliding window with a one-cycle valid
// strobe; K-1 chained line buffers feed the new column of the shift window.
module conv_window_buffer
    import conv_window_buffer_pkg::*;
#(
    parameter int KERNEL_SIZE  = DEF_KERNEL_SIZE,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [DATA_WIDTH-1:0]                         pixel_in,
    input  logic                                          pixel_valid,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_out,
    output logic                                          window_valid,
    output logic [$clog2(IMAGE_HEIGHT)-1:0]               out_row,
    output logic [$clog2(IMAGE_WIDTH)-1:0]                out_col,
    output logic                                          frame_done
);

    localparam int K  = KERNEL_SIZE;
    localparam int RW = $clog2(IMAGE_HEIGHT);
    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);

    logic [RW-1:0] row;
    logic [CW-1:0] col;

    // tap[i] is the pixel at the current column, i rows above the incoming one.
    logic [K-1:0][DATA_WIDTH-1:0] tap;
    logic [DATA_WIDTH-1:0]        win [K][K];

    assign tap[0] = pixel_in;

    generate
        for (genvar i = 0; i < K - 1; i++) begin : g_lb
            conv_window_buffer_line_buffer #(
                .DEPTH      (IMAGE_WIDTH),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_lb (
                .clk      (clk),
                .rst_n    (rst_n),
                .shift_en (pixel_valid),
                .din      (tap[i]),
                .dout     (tap[i+1])
            );
        end
    endgenerate

    // NOTE: all state here uses non-blocking assignments so the shift reads
    // every element's pre-edge value regardless of loop order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row          <= '0;
            col          <= '0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            out_row      <= '0;
            out_col      <= '0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            if (pixel_valid) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) begin
                        win[r][c] <= win[r][c+1];
                    end
                    win[r][K-1] <= tap[K-1-r];
                end
                // Column gating also rejects windows that straddle a row wrap.
                if (row >= ROW_WIN && col >= COL_WIN) begin
                    window_valid <= 1'b1;
                    out_row      <= row - ROW_WIN;
                    out_col      <= col - COL_WIN;
                end
                if (col == COL_LAST) begin
                    col <= '0;
                    if (row == ROW_LAST) begin
                        row        <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // NOTE: defaulting the whole vector first keeps this block latch-free.
    always_comb begin
        window_out = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                window_out[win_idx(r, c, K)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
            end
        end
    end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Scoreboard bench: small 8x6 frame instance plus a default-size instance
// whose windows are run through a Q8.8 multiply-accumulate model.
module tb_conv_window_buffer;

    localparam int K  = 5;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 16;
    localparam int WB = K * K * DW;
    localparam int BW = 28;
    localparam int BH = 28;

    typedef struct packed {
        logic [WB-1:0] win;
        logic [2:0]    row;
        logic [2:0]    col;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] pixel_in;
    logic          pixel_valid;
    logic [WB-1:0] window_out;
    logic          window_valid;
    logic [2:0]    out_row;
    logic [2:0]    out_col;
    logic          frame_done;

    logic [DW-1:0] pixel_in2;
    logic          pixel_valid2;
    logic [WB-1:0] window_out2;
    logic          window_valid2;
    logic [4:0]    out_row2;
    logic [4:0]    out_col2;
    logic          frame_done2;

    int   checks = 0;
    int   errors = 0;
    int   m_row  = 0;
    int   m_col  = 0;
    bit   pend_valid = 0, pend_done = 0;
    bit   cur_valid  = 0, cur_done  = 0;
    bit   mon_en     = 0;
    int   valid_cnt = 0, done_cnt = 0;
    int   big_valid_cnt = 0, big_done_cnt = 0;
    int   acc;
    exp_t mon_e;
    exp_t exp_q [$];
    exp_t seen_q [$];
    exp_t ref_q [$];

    conv_window_buffer #(
        .KERNEL_SIZE (K), .DATA_WIDTH (DW), .IMAGE_WIDTH (W), .IMAGE_HEIGHT (H)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pixel_in     (pixel_in),
        .pixel_valid  (pixel_valid),
        .window_out   (window_out),
        .window_valid (window_valid),
        .out_row      (out_row),
        .out_col      (out_col),
        .frame_done   (frame_done)
    );

    conv_window_buffer dut_big (
        .clk          (clk),
        .rst_n        (rst_n),
        .pixel_in     (pixel_in2),
        .pixel_valid  (pixel_valid2),
        .window_out   (window_out2),
        .window_valid (window_valid2),
        .out_row      (out_row2),
        .out_col      (out_col2),
        .frame_done   (frame_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [DW-1:0] pix(input logic [DW-1:0] base, input int r, input int c);
        return base + DW'((r * W + c) << 8);
    endfunction

    // Expected window whose bottom-right pixel is (r, c).
    function automatic logic [WB-1:0] exp_win(input logic [DW-1:0] base, input int r, input int c);
        logic [WB-1:0] w;
        w = '0;
        for (int wr = 0; wr < K; wr++) begin
            for (int wc = 0; wc < K; wc++) begin
                w[(wr*K + wc)*DW +: DW] = pix(base, r - K + 1 + wr, c - K + 1 + wc);
            end
        end
        return w;
    endfunction

    always @(posedge clk) begin
        cur_valid <= pend_valid;
        cur_done  <= pend_done;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (window_valid !== cur_valid) begin
                errors++;
                $display("FAIL valid_timing: got %b expected %b at %0t", window_valid, cur_valid, $time);
            end
            checks++;
            if (frame_done !== cur_done) begin
                errors++;
                $display("FAIL frame_done_timing: got %b expected %b at %0t", frame_done, cur_done, $time);
            end
            if (window_valid === 1'b1) begin
                valid_cnt++;
                seen_q.push_back('{win: window_out, row: out_row, col: out_col});
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_window: row %0d col %0d at %0t", out_row, out_col, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (window_out !== mon_e.win || out_row !== mon_e.row || out_col !== mon_e.col) begin
                        errors++;
                        $display("FAIL window_data: got row %0d col %0d win %h expected row %0d col %0d win %h",
                                 out_row, out_col, window_out, mon_e.row, mon_e.col, mon_e.win);
                    end
                end
            end
            if (frame_done === 1'b1) done_cnt++;
            if (window_valid2 === 1'b1) begin
                big_valid_cnt++;
                acc = 0;
                for (int e = 0; e < K * K; e++) begin
                    acc += (int'($signed(window_out2[e*DW +: DW])) * 256) >>> 8;
                end
                checks++;
                if (acc !== 32'h3200) begin
                    errors++;
                    $display("FAIL mac_result: got %h expected 3200 at row %0d col %0d", acc, out_row2, out_col2);
                end
            end
            if (frame_done2 === 1'b1) big_done_cnt++;
        end
    end

    task automatic drive(input bit v, input logic [DW-1:0] base);
        @(posedge clk);
        #1;
        pixel_valid = v;
        pixel_in    = v ? pix(base, m_row, m_col) : DW'($urandom);
        pend_valid  = v && m_row >= K - 1 && m_col >= K - 1;
        pend_done   = v && m_row == H - 1 && m_col == W - 1;
        if (pend_valid)
            exp_q.push_back('{win: exp_win(base, m_row, m_col), row: 3'(m_row - K + 1), col: 3'(m_col - K + 1)});
        if (v) begin
            if (m_col == W - 1) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic stream(input logic [DW-1:0] base, input int gap_pct, input int npix);
        int accepted = 0;
        int cycles   = 0;
        bit v;
        while (accepted < npix && cycles < 5000) begin
            v = (gap_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= gap_pct);
            drive(v, base);
            if (v) accepted++;
            cycles++;
        end
        checks++;
        if (accepted != npix) begin
            errors++;
            $display("FAIL stream_budget: accepted %0d expected %0d", accepted, npix);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0);
    endtask

    task automatic clear_stats();
        valid_cnt = 0;
        done_cnt  = 0;
        seen_q.delete();
    endtask

    task automatic check_counts(input string name, input int exp_valid, input int exp_done);
        checks++;
        if (valid_cnt != exp_valid || done_cnt != exp_done || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_counts: valids %0d dones %0d pending %0d expected valids %0d dones %0d pending 0",
                     name, valid_cnt, done_cnt, exp_q.size(), exp_valid, exp_done);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        pixel_valid  = 1'b0;
        pixel_valid2 = 1'b0;
        pend_valid   = 1'b0;
        pend_done    = 1'b0;
        m_row        = 0;
        m_col        = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        checks++;
        if (window_out !== '0 || window_valid !== 1'b0 || out_row !== 3'd0 ||
            out_col !== 3'd0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: win %h valid %b row %0d col %0d done %b expected all zero",
                     window_out, window_valid, out_row, out_col, frame_done);
        end
        checks++;
        if (window_out2 !== '0 || window_valid2 !== 1'b0 || frame_done2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs_big: valid %b done %b expected zero", window_valid2, frame_done2);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pixel_valid = 1'b0;
        pixel_in = '0;
        pixel_valid2 = 1'b0;
        pixel_in2 = '0;
        repeat (2) @(posedge clk);
        apply_reset();
        mon_en = 1'b1;
    endtask

    task automatic test_stream();
        logic [WB-1:0] w;
        clear_stats();
        stream(16'h0000, 0, W * H);
        idle(3);
        check_counts("stream", 8, 1);
        if (seen_q.size() >= 5) begin
            w = seen_q[0].win;
            checks++;
            if (w[0 +: DW] !== 16'h0000 || w[24*DW +: DW] !== 16'h2400 || w[12*DW +: DW] !== 16'h1200 ||
                seen_q[0].row !== 3'd0 || seen_q[0].col !== 3'd0) begin
                errors++;
                $display("FAIL first_window: e0 %h e12 %h e24 %h row %0d col %0d expected 0000 1200 2400 0 0",
                         w[0 +: DW], w[12*DW +: DW], w[24*DW +: DW], seen_q[0].row, seen_q[0].col);
            end
            w = seen_q[4].win;
            checks++;
            if (seen_q[4].row !== 3'd1 || seen_q[4].col !== 3'd0 || w[0 +: DW] !== 16'h0800) begin
                errors++;
                $display("FAIL row_wrap_window: row %0d col %0d e0 %h expected 1 0 0800",
                         seen_q[4].row, seen_q[4].col, w[0 +: DW]);
            end
        end
        ref_q = seen_q;
    endtask

    task automatic test_gaps();
        clear_stats();
        stream(16'h0000, 40, W * H);
        idle(3);
        check_counts("gaps", 8, 1);
        checks++;
        if (seen_q != ref_q) begin
            errors++;
            $display("FAIL gap_sequence: %0d windows differ from gapless run of %0d", seen_q.size(), ref_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        stream(16'h0000, 0, 20);
        apply_reset();
        clear_stats();
        stream(16'h0000, 0, W * H);
        idle(3);
        check_counts("mid_reset", 8, 1);
    endtask

    task automatic test_back_to_back();
        logic [WB-1:0] w;
        clear_stats();
        stream(16'h0000, 0, W * H);
        stream(16'h4000, 0, W * H);
        idle(3);
        check_counts("back_to_back", 16, 2);
        if (seen_q.size() >= 9) begin
            w = seen_q[8].win;
            checks++;
            if (w[0 +: DW] !== 16'h4000) begin
                errors++;
                $display("FAIL frame2_first_window: e0 %h expected 4000", w[0 +: DW]);
            end
        end
    endtask

    task automatic test_integration();
        big_valid_cnt = 0;
        big_done_cnt  = 0;
        for (int i = 0; i < BW * BH; i++) begin
            @(posedge clk);
            #1;
            pixel_valid2 = 1'b1;
            pixel_in2    = 16'h0200;
            pend_valid   = 1'b0;
            pend_done    = 1'b0;
            pixel_valid  = 1'b0;
        end
        @(posedge clk);
        #1;
        pixel_valid2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (big_valid_cnt != (BW - K + 1) * (BH - K + 1) || big_done_cnt != 1) begin
            errors++;
            $display("FAIL integration_counts: valids %0d dones %0d expected 576 1", big_valid_cnt, big_done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_gaps();
        test_reset_mid_frame();
        test_back_to_back();
        test_integration();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_window_buffer.md
Name: conv_window_buffer

Overview:
- Streaming upstream stage for the multiplier / adder_tree datapath.
- Accepts one raster-order pixel per cycle from the frame source.
- Keeps KERNEL_SIZE-1 line buffers and a KERNEL_SIZE x KERNEL_SIZE shift window.
- Presents a fully populated packed window on `window_out`, wired straight to the multiplier `pixel_data` input, together with a one-cycle `window_valid` strobe.

Parameters:
- KERNEL_SIZE, 5: window edge length; window holds KERNEL_SIZE**2 elements.
- DATA_WIDTH, 16: pixel width, signed Q8.8.
- IMAGE_WIDTH, 28: pixels per row; must be >= KERNEL_SIZE.
- IMAGE_HEIGHT, 28: rows per frame; must be >= KERNEL_SIZE.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- pixel_in  in  DATA_WIDTH  input pixel, raster order (row-major, left to right).
- pixel_valid  in  1  pixel_in is accepted this cycle. No backpressure; the block always accepts.
- window_out  out  (KERNEL_SIZE**2)*DATA_WIDTH  packed window; element e sits at [e*DATA_WIDTH +: DATA_WIDTH], with e = r*KERNEL_SIZE + c (r=0 is the oldest/top row, c=0 the leftmost column).
- window_valid  out  1  one-cycle strobe marking window_out as a complete window.
- out_row  out  $clog2(IMAGE_HEIGHT)  row of the window's top-left pixel.
- out_col  out  $clog2(IMAGE_WIDTH)  column of the window's top-left pixel.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - row/col counters, window_out, window_valid, out_row, out_col and frame_done all go to 0.
  - Line-buffer RAM contents are don't-care; they are never observed before being overwritten.
- Accept cycle (pixel_valid=1) at counter position (row, col):
  - Every window row shifts left by one element.
  - New column entering at c=KERNEL_SIZE-1: rows 0..K-2 come from line-buffer taps (the pixel at the same column, K-1..1 rows above); row K-1 takes pixel_in.
  - Line buffers advance: each is an IMAGE_WIDTH-deep delay, chained.
  - col increments. At col=IMAGE_WIDTH-1 it wraps to 0 and row increments.
  - At row=IMAGE_HEIGHT-1 and col=IMAGE_WIDTH-1, both wrap to 0 and frame_done=1 on the next cycle.
- Output timing:
  - window_valid=1 exactly one cycle after accepting (row, col) with row>=K-1 and col>=K-1.
  - In that cycle window_out holds rows row-K+1..row and cols col-K+1..col, out_row=row-K+1, out_col=col-K+1.
  - Latency is 1 clock from accept to valid.
- Idle cycle (pixel_valid=0):
  - All state holds; window_valid=0 and frame_done=0.
  - window_out keeps its last value.
- Row wrap: windows spanning the end of one row and the start of the next are never flagged valid; the col>=K-1 gating guarantees this.
- Count: exactly (IMAGE_WIDTH-K+1)*(IMAGE_HEIGHT-K+1) valids per frame.
- Back-to-back frames: the first pixel of frame N+1 may arrive in the cycle after the last pixel of frame N. No bubble is required, and no stale window from frame N is ever flagged valid in frame N+1.
- Reset mid-frame: counters restart, the partial frame is discarded, and no window_valid fires until K-1 full rows plus K pixels of the new frame have been accepted.
- Arithmetic: pure data movement; no sign extension or rounding.

Decomposition:
- Shared header conv_params.vh holds KERNEL_SIZE, DATA_WIDTH, IMAGE_WIDTH, IMAGE_HEIGHT defaults and the window-index macro (r*KERNEL_SIZE+c). The multiplier and adder_tree use the same header.
- One sub-module, line_buffer: an IMAGE_WIDTH-deep, DATA_WIDTH-wide delay line with a shift enable (pixel_valid). It is instantiated KERNEL_SIZE-1 times via generate.
- Counters and the window shift register live in the top module.

Test Plan:
1. Bench configuration IMAGE_WIDTH=8, IMAGE_HEIGHT=6, K=5. Stream pixel value = (row*8+col) in integer Q8.8 with no gaps.
   - First window_valid comes one cycle after pixel index 36 (row 4, col 4).
   - Element 0 = 0x0000, element 24 = 0x2400, element 12 = 0x1200; out_row=0, out_col=0.
   - Exactly 8 valids in total, then one frame_done.
2. Same frame with pixel_valid randomly deasserted about 40% of cycles:
   - The sequence of window_out / out_row / out_col values is identical to scenario 1.
   - No valid or frame_done fires during gap cycles.
3. Row-wrap check:
   - No valid is flagged after pixels (5,0)..(5,3).
   - The valid after pixel (5,4) has out_row=1, out_col=0, element 0 = 0x0800.
4. Reset mid-frame: assert rst_n=0 for 1 cycle after 20 pixels, then stream a full frame.
   - Outputs are 0 during reset.
   - No stray valid; exactly 8 valids and 1 frame_done follow.
5. Two back-to-back frames, the second with values +0x4000:
   - 16 valids and 2 frame_done pulses.
   - The first valid of frame 2 has element 0 = 0x4000.
6. Integration at defaults (28x28): stream all pixels 0x0200 into the window buffer feeding the multiplier, with all weights 0x0100, then the adder_tree with bias 0.
   - Every flagged window produces an adder_tree result of 0x3200 (50.0).
   - 576 valids per frame.
